// File: rtl/fetch_redirect_unit_if.sv
// Fetch front-end bundle: instruction-memory request/response, execute redirect,
// and the decode-side instruction handshake.
interface fetch_redirect_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            id_ready;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            misalign;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, misalign,
        input  imem_gnt, imem_rvalid, imem_rdata, br_taken, br_target, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, misalign,
        output imem_gnt, imem_rvalid, imem_rdata, br_taken, br_target, id_ready
    );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end: owns the PC, keeps one imem request outstanding,
// buffers words in an output + skid pair, and re-steers on execute redirects.
module fetch_redirect_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_redirect_unit_if.master fe
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_out_valid;
    logic [31:0]     r_out_instr;
    logic [XLEN-1:0] r_out_pc;
    logic [31:0]     r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;
    logic            r_misalign;

    logic w_fire_req;
    logic w_out_free;
    logic w_load_mem;
    logic w_load_skid;
    logic w_skid_to_out;

    assign w_fire_req    = (r_state == S_REQ) & fe.imem_gnt;
    assign w_out_free    = ~r_out_valid | fe.id_ready;
    assign w_load_mem    = (r_state == S_WAIT) & fe.imem_rvalid & w_out_free & ~fe.br_taken;
    assign w_load_skid   = (r_state == S_WAIT) & fe.imem_rvalid & ~w_out_free & ~fe.br_taken;
    assign w_skid_to_out = (r_state == S_HOLD) & fe.id_ready & ~fe.br_taken;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_REQ;
        else        r_state <= w_next_state;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        if (fe.br_taken) begin
            // Park in S_DROP only if a response is still owed after this edge.
            unique case (r_state)
                S_REQ:   w_next_state = fe.imem_gnt    ? S_DROP : S_REQ;
                S_WAIT:  w_next_state = fe.imem_rvalid ? S_REQ  : S_DROP;
                S_DROP:  w_next_state = fe.imem_rvalid ? S_REQ  : S_DROP;
                default: w_next_state = S_REQ;
            endcase
        end else begin
            unique case (r_state)
                S_REQ:   if (fe.imem_gnt) w_next_state = S_WAIT;
                S_WAIT:  if (fe.imem_rvalid) w_next_state = w_out_free ? S_REQ : S_HOLD;
                S_HOLD:  if (fe.id_ready) w_next_state = S_REQ;
                S_DROP:  if (fe.imem_rvalid) w_next_state = S_REQ;
                default: w_next_state = S_REQ;
            endcase
        end
    end

    always_comb begin
        fe.imem_req  = (r_state == S_REQ) & rst_n;
        fe.imem_addr = r_pc;
        fe.if_valid  = r_out_valid;
        fe.if_instr  = r_out_valid ? r_out_instr : NOP_INSTR;
        fe.if_pc     = r_out_pc;
        fe.misalign  = r_misalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_instr <= NOP_INSTR;
            r_out_pc    <= RESET_PC;
            r_misalign  <= 1'b0;
        end else begin
            r_misalign <= fe.br_taken & fe.br_target[1];

            if (fe.br_taken)     r_pc <= {fe.br_target[XLEN-1:2], 2'b00};
            else if (w_fire_req) r_pc <= r_pc + XLEN'(4);

            if (w_fire_req) r_req_pc <= r_pc;

            // A same-cycle transfer has already completed; the flush wins the edge.
            if (fe.br_taken) begin
                r_out_valid <= 1'b0;
            end else if (w_load_mem) begin
                r_out_valid <= 1'b1;
                r_out_instr <= fe.imem_rdata;
                r_out_pc    <= r_req_pc;
            end else if (w_skid_to_out) begin
                r_out_valid <= 1'b1;
                r_out_instr <= r_skid_instr;
                r_out_pc    <= r_skid_pc;
            end else if (fe.id_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // NOTE: the skid payload carries no reset; it is only meaningful in S_HOLD,
    // which is entered solely by loading it.
    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid_instr <= fe.imem_rdata;
            r_skid_pc    <= r_req_pc;
        end
    end
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Randomised bench for fetch_redirect_unit: memory model with variable latency,
// program-order reference model with epoch-based stale tracking, and a scoreboard.
module tb_fetch_redirect_unit;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_redirect_unit_if #(.XLEN(XLEN)) bus ();

    fetch_redirect_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .fe   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] model_pc;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    req_t        pend[$];
    item_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          epoch  = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic [31:0] exp_fetch_pc = RESET_PC;
    logic        exp_mis      = 1'b0;
    bit          chk_redirect = 1'b0;
    logic [31:0] redirect_pc  = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_if_valid"}, 32'(bus.if_valid), 32'd0);
        check({tag, "_if_instr"}, bus.if_instr, NOP);
        check({tag, "_if_pc"},    bus.if_pc, RESET_PC);
        check({tag, "_misalign"}, 32'(bus.misalign), 32'd0);
    endtask

    // One cycle of stimulus; the memory side answers the oldest due request.
    task automatic step(input bit g, input bit r, input bit b, input logic [31:0] t);
        @(posedge clk);
        #1;
        cyc++;
        bus.imem_gnt  = g;
        bus.id_ready  = r;
        bus.br_taken  = b;
        bus.br_target = t;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
    endtask

    task automatic sync_model();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 1023));
            2:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return 32'h0000_0100 | 32'($urandom_range(0, 3));
        endcase
    endfunction

    // Reference model: sequential fetch from the last steer point; a response
    // is delivered only if no redirect happened between its grant and its return.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            pend.delete();
            exp_q.delete();
            exp_fetch_pc = RESET_PC;
            exp_mis      = 1'b0;
            chk_redirect = 1'b0;
        end else begin
            if (chk_redirect) begin
                check("redirect_req",  32'(bus.imem_req), 32'd1);
                check("redirect_addr", bus.imem_addr, redirect_pc);
                chk_redirect = 1'b0;
            end
            if (bus.imem_req) begin
                check("req_outstanding", 32'(pend.size()), 32'd0);
                check("req_while_full",  32'(exp_q.size() == 2), 32'd0);
                if (bus.imem_gnt) begin
                    check("req_addr", bus.imem_addr, exp_fetch_pc);
                    pend.push_back('{bus.imem_addr, exp_fetch_pc, epoch,
                                     cyc + $urandom_range(lat_lo, lat_hi)});
                    exp_fetch_pc = exp_fetch_pc + 32'd4;
                end
            end
            if (bus.imem_rvalid && pend.size() > 0) begin
                if (pend[0].epoch == epoch && !bus.br_taken)
                    exp_q.push_back('{pend[0].model_pc, mem_word(pend[0].model_pc)});
                void'(pend.pop_front());
            end
            if (bus.br_taken) begin
                epoch++;
                exp_q.delete();
                exp_fetch_pc = {bus.br_target[31:2], 2'b00};
                exp_mis      = bus.br_target[1];
                if (pend.size() == 0) begin
                    chk_redirect = 1'b1;
                    redirect_pc  = exp_fetch_pc;
                end
            end else begin
                exp_mis = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every decode transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            check("misalign", 32'(bus.misalign), 32'(exp_mis));
            check("if_valid", 32'(bus.if_valid), 32'(exp_q.size() > 0));
            if (bus.if_valid && exp_q.size() > 0) begin
                check("if_pc",    bus.if_pc,    exp_q[0].pc);
                check("if_instr", bus.if_instr, exp_q[0].instr);
                if (bus.id_ready) void'(exp_q.pop_front());
            end else if (!bus.if_valid) begin
                check("if_instr_nop", bus.if_instr, NOP);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        bus.imem_gnt    = 1'b0;
        bus.id_ready    = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming at one-cycle latency.
        lat_lo = 1; lat_hi = 1;
        repeat (20) step(1, 1, 0, 32'h0);

        // Back-pressure fills the skid, then release.
        lat_hi = 2;
        repeat (10) step(1, 0, 0, 32'h0);
        repeat (10) step(1, 1, 0, 32'h0);

        // Redirect while waiting; stale word returns two cycles later.
        lat_lo = 3; lat_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 1, 0, 32'h0);
            sync_model();
            found = (pend.size() > 0);
        end
        check("s3_reached", 32'(found), 32'd1);
        step(1, 1, 1, 32'h0000_0100);
        repeat (12) step(1, 1, 0, 32'h0);

        // Misaligned redirect targets.
        lat_lo = 1; lat_hi = 2;
        step(0, 1, 1, 32'h0000_0203);
        repeat (6) step(1, 1, 0, 32'h0);
        step(0, 1, 1, 32'h0000_0201);
        repeat (6) step(1, 1, 0, 32'h0);

        // PC wrap-around.
        lat_hi = 1;
        step(0, 1, 1, 32'hFFFF_FFFC);
        repeat (8) step(1, 1, 0, 32'h0);

        // Reset asserted while a response is owed.
        lat_lo = 3; lat_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 1, 0, 32'h0);
            sync_model();
            found = (pend.size() > 0);
        end
        check("s5_reached", 32'(found), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        bus.imem_rvalid = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("refetch_req",  32'(bus.imem_req), 32'd1);
        check("refetch_addr", bus.imem_addr, RESET_PC);

        // Redirect, response and decode transfer all in one cycle.
        lat_lo = 2; lat_hi = 2;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (bus.if_valid && pend.size() > 0 && pend[0].due == cyc + 1) begin
                step(1, 1, 1, 32'h0000_0300);
                found = 1'b1;
            end else begin
                step(1, 0, 0, 32'h0);
            end
            sync_model();
        end
        check("s6_reached", 32'(found), 32'd1);
        repeat (6) step(1, 1, 0, 32'h0);

        // Randomised traffic.
        begin
            int bias = 2;
            for (int i = 0; i < 3000; i++) begin
                if (i % 250 == 0) begin
                    lat_lo = 1;
                    lat_hi = $urandom_range(1, 4);
                    bias   = $urandom_range(1, 4);
                end
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 4) < bias,
                     $urandom_range(0, 24) == 0,
                     rand_target());
            end
        end

        // Drain: stop granting so the outstanding request and buffers empty.
        repeat (12) step(0, 1, 0, 32'h0);
        sync_model();
        check("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        check("drain_pending",    32'(pend.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
